alu_writeback_stage: RTL and testbench
======================================

Name: alu_writeback_stage

Overview:
- Sits directly downstream of the vector-lane ALU and consumes its per-element outputs: finalResult and predicate.
- Registers the results into a 2-entry buffer with valid/ready flow control.
- Sequences element indices 0..vl-1 and issues writes to the vector register file (VRF) write port, absorbing VRF backpressure.
- Signals completion of one vector instruction with a single-cycle done pulse.

Parameters:
- WIDTH, 32, element/result width; matches the ALU WIDTH.
- VLEN_W, 8, width of vector-length and element-index fields.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins an instruction; sampled only in IDLE.
- vl  in  VLEN_W  element count; captured on start.
- in_valid  in  1  ALU result valid.
- in_ready  out  1  stage can accept a result.
- in_result  in  WIDTH  ALU finalResult.
- in_predicate  in  1  ALU predicate for this element.
- wr_en  out  1  VRF write strobe.
- wr_idx  out  VLEN_W  element index of the write.
- wr_data  out  WIDTH  write data.
- wr_ready  in  1  VRF accepts the write this cycle.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: in_ready=0, wr_en=0, wr_idx=0, wr_data=0, busy=0, done=0.
- Reset clears the FIFO, all counters and the FSM to IDLE. Reset mid-instruction discards buffered elements with no write emitted.
- Internal state:
  - Buffer: 2-entry FIFO of {result, predicate}.
  - acc_cnt: elements accepted.
  - pop_cnt: elements retired; drives wr_idx.
  - vl_q: captured vl.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start with vl!=0: capture vl_q, clear counters, go to RUN.
  - start with vl==0: go to DONE directly; no writes.
  - start while busy: ignored.
- RUN:
  - in_ready = (fifo_cnt<2) && (acc_cnt<vl_q). It is registered-state only; there is no combinational path from wr_ready to in_ready.
  - A push occurs when in_valid && in_ready.
  - When acc_cnt reaches vl_q (including by the push in this cycle), go to DRAIN.
- DRAIN:
  - in_ready=0.
  - When the FIFO is empty and pop_cnt==vl_q, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Retire rule (RUN or DRAIN, FIFO non-empty):
  - If the head element is active, wr_en=1, wr_data=head result, wr_idx=pop_cnt. The element pops only when wr_ready=1.
  - If the head element is inactive, it pops unconditionally in one cycle with wr_en=0.
  - Each pop increments pop_cnt.
- Latency: an element accepted in cycle N appears on wr_en no earlier than cycle N+1. The minimum start-to-done time for vl elements with no stalls is vl+3 cycles.
- Simultaneous push and pop with fifo_cnt==1 or 2: legal, and the count is unchanged.
- fifo_cnt never exceeds 2. Counters are VLEN_W wide and never wrap, since acc_cnt<=vl_q.
- wr_en, wr_idx and wr_data must be held stable while wr_en=1 and wr_ready=0.

Optional Feature:
- Macro: ALU_WB_PRED_MASK_EN.
- Defined: element active = stored predicate. Inactive elements are skipped without a write, but still consume an index.
- Undefined: every element is active and in_predicate is ignored (not stored).

Decomposition:
- Shared package alu_wb_pkg:
  - wb_state_e enum {IDLE, RUN, DRAIN, DONE}.
  - wb_entry_t struct {logic [WIDTH-1:0] data; logic pred;}.
  - Constant WB_FIFO_DEPTH=2.
- One sub-module: wb_fifo2, a 2-entry synchronous FIFO with push, pop, full, empty, count and head output. It uses the same clk/rst_n.

Test Plan:
- Streaming: vl=4, in_valid=1 continuously, results 0x10..0x13, wr_ready=1 → writes at idx 0..3 with data 0x10..0x13; done at cycle start+7; busy low the next cycle.
- Backpressure: vl=4, wr_ready=0 for 4 cycles after the first wr_en → wr_en/idx/data held stable; FIFO fills; in_ready=0 while full; no element lost or duplicated; final write order 0..3.
- Predicate: vl=4, predicates 1,0,1,0.
  - With ALU_WB_PRED_MASK_EN: writes only idx 0 and 2.
  - Without the macro: writes idx 0..3.
  - done asserts once in both cases.
- Zero length: start with vl=0 → done on the cycle after start; never wr_en or in_ready.
- Reset mid-run: vl=8, assert rst_n low after 3 accepts → all outputs go to their reset values immediately. A new start with vl=2 afterwards writes idx 0..1 only.
- Start while busy: a second start during RUN with a different vl → ignored; the original vl completes unchanged.

Source files
------------

// File: rtl/alu_wb_pkg.sv
// Shared types and constants for the ALU writeback stage: FSM states,
// buffered entry layout and FIFO sizing.
package alu_wb_pkg;

  localparam int WB_WIDTH      = 32;
  localparam int WB_VLEN_W     = 8;
  localparam int WB_FIFO_DEPTH = 2;
  localparam int WB_CNT_W      = $clog2(WB_FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } wb_state_e;

  typedef struct packed {
    logic [WB_WIDTH-1:0] data;
    logic                pred;
  } wb_entry_t;

endpackage

// File: rtl/alu_writeback_stage_if.sv
// Handshake bundle for the writeback stage: the ALU result stream in, and the
// VRF write port out. The stage attaches through the slave modport.
interface alu_writeback_stage_if
  import alu_wb_pkg::*;
#(
  parameter int WIDTH  = WB_WIDTH,
  parameter int VLEN_W = WB_VLEN_W
);

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_result;
  logic              in_predicate;
  logic              wr_en;
  logic [VLEN_W-1:0] wr_idx;
  logic [WIDTH-1:0]  wr_data;
  logic              wr_ready;

  modport master (
    output in_valid, in_result, in_predicate, wr_ready,
    input  in_ready, wr_en, wr_idx, wr_data
  );

  modport slave (
    input  in_valid, in_result, in_predicate, wr_ready,
    output in_ready, wr_en, wr_idx, wr_data
  );

endinterface

// File: rtl/wb_fifo2.sv
// Two-entry synchronous FIFO holding {result, predicate} entries; the head
// entry is presented combinationally so it can drive the VRF write port.
module wb_fifo2
  import alu_wb_pkg::*;
#(
  parameter type entry_t = wb_entry_t
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push_i,
  input  entry_t              din_i,
  input  logic                pop_i,
  output entry_t              head_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [WB_CNT_W-1:0] count_o
);

  entry_t              mem_q [WB_FIFO_DEPTH];
  logic                wr_ptr_q;
  logic                rd_ptr_q;
  logic [WB_CNT_W-1:0] count_q;
  logic                do_push;
  logic                do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == WB_CNT_W'(WB_FIFO_DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: storage is reset as well so the head (and thus wr_data) reads
      // zero out of reset; at two entries this costs almost nothing.
      for (int i = 0; i < WB_FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + WB_CNT_W'(1);
        2'b01:   count_q <= count_q - WB_CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/alu_writeback_stage.sv
// Buffers per-element ALU results and retires them in index order to the VRF.
// Optional ALU_WB_PRED_MASK_EN: inactive-predicate elements skip their write.
module alu_writeback_stage
  import alu_wb_pkg::*;
#(
  parameter int WIDTH  = WB_WIDTH,
  parameter int VLEN_W = WB_VLEN_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [VLEN_W-1:0]     vl,
  alu_writeback_stage_if.slave  bus,
  output logic                  busy,
  output logic                  done
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             pred;
  } entry_t;

  wb_state_e           state_q, state_d;
  logic [VLEN_W-1:0]   vl_q, vl_d;
  logic [VLEN_W-1:0]   acc_cnt_q, acc_cnt_d;
  logic [VLEN_W-1:0]   pop_cnt_q, pop_cnt_d;

  entry_t              push_entry;
  entry_t              fifo_head;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [WB_CNT_W-1:0] fifo_cnt;
  logic                head_active;
  logic                in_ready;
  logic                wr_en;
  logic [WIDTH-1:0]    wr_data;

`ifdef ALU_WB_PRED_MASK_EN
  assign push_entry  = '{data: bus.in_result, pred: bus.in_predicate};
  assign head_active = fifo_head.pred;
`else
  // Every element is written; the predicate bit is tied off and never used.
  logic unused_pred;
  assign push_entry  = '{data: bus.in_result, pred: 1'b1};
  assign head_active = 1'b1;
  assign unused_pred = bus.in_predicate ^ fifo_head.pred;
`endif

  wb_fifo2 #(.entry_t(entry_t)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .din_i   (push_entry),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      vl_q      <= '0;
      acc_cnt_q <= '0;
      pop_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      vl_q      <= vl_d;
      acc_cnt_q <= acc_cnt_d;
      pop_cnt_q <= pop_cnt_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a latch behind.
    state_d   = state_q;
    vl_d      = vl_q;
    acc_cnt_d = acc_cnt_q;
    pop_cnt_d = pop_cnt_q;
    in_ready  = 1'b0;
    wr_en     = 1'b0;
    wr_data   = '0;
    done      = 1'b0;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;

    // Active heads wait for the VRF; inactive heads retire in one cycle.
    if ((state_q == RUN || state_q == DRAIN) && !fifo_empty) begin
      if (head_active) begin
        wr_en    = 1'b1;
        wr_data  = fifo_head.data;
        fifo_pop = bus.wr_ready;
      end else begin
        fifo_pop = 1'b1;
      end
    end
    if (fifo_pop) pop_cnt_d = pop_cnt_q + VLEN_W'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          if (vl != '0) begin
            vl_d      = vl;
            acc_cnt_d = '0;
            pop_cnt_d = '0;
            state_d   = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        // Depends on registered state only, never on wr_ready.
        in_ready  = (fifo_cnt < WB_CNT_W'(WB_FIFO_DEPTH)) && (acc_cnt_q < vl_q);
        fifo_push = bus.in_valid && in_ready;
        if (fifo_push) acc_cnt_d = acc_cnt_q + VLEN_W'(1);
        if (acc_cnt_d == vl_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty && pop_cnt_q == vl_q) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready = in_ready;
  assign bus.wr_en    = wr_en;
  assign bus.wr_idx   = pop_cnt_q;
  assign bus.wr_data  = wr_data;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed bench for alu_writeback_stage: streaming, VRF backpressure,
// predicates, zero length, reset mid-instruction and start while busy.
module tb_alu_writeback_stage;

  localparam int WIDTH  = 32;
  localparam int VLEN_W = 8;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [VLEN_W-1:0] vl    = '0;
  logic              busy;
  logic              done;

  alu_writeback_stage_if #(.WIDTH(WIDTH), .VLEN_W(VLEN_W)) bus ();

  alu_writeback_stage #(.WIDTH(WIDTH), .VLEN_W(VLEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .vl    (vl),
    .bus   (bus.slave),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // ALU source model: offers elements src_lo..src_hi-1 in order.
  logic [WIDTH-1:0]  src_res  [64];
  logic              src_pred [64];
  int                src_lo = 0;
  int                src_hi = 0;
  int                src_pos = 0;

  // Observation log, written only by the monitor.
  logic [VLEN_W-1:0] w_idx [$];
  logic [WIDTH-1:0]  w_data [$];
  int                done_cnt = 0;
  int                done_cyc = 0;
  int                wr_en_cnt = 0;
  int                in_ready_cnt = 0;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (bus.wr_en) wr_en_cnt = wr_en_cnt + 1;
    if (bus.in_ready) in_ready_cnt = in_ready_cnt + 1;
    if (bus.wr_en && bus.wr_ready) begin
      w_idx.push_back(bus.wr_idx);
      w_data.push_back(bus.wr_data);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  initial begin : alu_source
    bus.in_valid     = 1'b0;
    bus.in_result    = '0;
    bus.in_predicate = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (src_pos < src_lo) src_pos = src_lo;
      if (src_pos < src_hi) begin
        bus.in_valid     = 1'b1;
        bus.in_result    = src_res[src_pos];
        bus.in_predicate = src_pred[src_pos];
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) src_pos = src_pos + 1;
    end
  end

  task automatic load_src(input int n, input logic [WIDTH-1:0] base, input logic [15:0] preds);
    @(negedge clk); #1;
    src_lo = src_hi;
    for (int i = 0; i < n; i++) begin
      src_res[src_lo + i]  = base + WIDTH'(i);
      src_pred[src_lo + i] = preds[i];
    end
    src_hi = src_lo + n;
  endtask

  task automatic do_start(input logic [VLEN_W-1:0] v, output int start_cyc);
    @(posedge clk); #1;
    start     = 1'b1;
    vl        = v;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int base);
    int i;
    for (i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (done_cnt > base) break;
    end
    n_cmp++;
    if (done_cnt <= base) begin
      n_err++;
      $display("FAIL %s_timeout: got no done pulse expected one within 200 cycles", name);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %0h expected 0", bus.in_ready); end
    n_cmp++; if (bus.wr_en    !== 1'b0) begin n_err++; $display("FAIL reset_wr_en: got %0h expected 0", bus.wr_en); end
    n_cmp++; if (bus.wr_idx   !== '0)   begin n_err++; $display("FAIL reset_wr_idx: got %0h expected 0", bus.wr_idx); end
    n_cmp++; if (bus.wr_data  !== '0)   begin n_err++; $display("FAIL reset_wr_data: got %0h expected 0", bus.wr_data); end
    n_cmp++; if (busy         !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0h expected 0", busy); end
    n_cmp++; if (done         !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0h expected 0", done); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_streaming();
    int s, wb, db;
    bus.wr_ready = 1'b1;
    wb = w_idx.size();
    db = done_cnt;
    load_src(4, 32'h10, 16'hF);
    do_start(4, s);
    wait_done("stream", db);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stream_busy_after_done: got %0h expected 0", busy); end
    n_cmp++; if (done_cyc - s !== 7) begin n_err++; $display("FAIL stream_done_latency: got %0d expected 7", done_cyc - s); end
    n_cmp++; if (w_idx.size() - wb !== 4) begin n_err++; $display("FAIL stream_write_count: got %0d expected 4", w_idx.size() - wb); end
    for (int i = 0; i < 4; i++) begin
      if (w_idx.size() > wb + i) begin
        n_cmp++; if (w_idx[wb+i] !== VLEN_W'(i)) begin n_err++; $display("FAIL stream_idx%0d: got %0d expected %0d", i, w_idx[wb+i], i); end
        n_cmp++; if (w_data[wb+i] !== 32'h10 + WIDTH'(i)) begin n_err++; $display("FAIL stream_data%0d: got %0h expected %0h", i, w_data[wb+i], 32'h10 + i); end
      end
    end
    n_cmp++; if (done_cnt - db !== 1) begin n_err++; $display("FAIL stream_done_count: got %0d expected 1", done_cnt - db); end
  endtask

  task automatic test_backpressure();
    int s, wb, db, k;
    bus.wr_ready = 1'b0;
    wb = w_idx.size();
    db = done_cnt;
    load_src(4, 32'h20, 16'hF);
    do_start(4, s);
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.wr_en) break;
    end
    n_cmp++; if (bus.wr_en !== 1'b1) begin n_err++; $display("FAIL bp_first_wr_en: got %0h expected 1", bus.wr_en); end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++; if (bus.wr_en !== 1'b1) begin n_err++; $display("FAIL bp_hold_wr_en%0d: got %0h expected 1", i, bus.wr_en); end
      n_cmp++; if (bus.wr_idx !== '0) begin n_err++; $display("FAIL bp_hold_idx%0d: got %0d expected 0", i, bus.wr_idx); end
      n_cmp++; if (bus.wr_data !== 32'h20) begin n_err++; $display("FAIL bp_hold_data%0d: got %0h expected 20", i, bus.wr_data); end
    end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_full: got %0h expected 0", bus.in_ready); end
    @(posedge clk); #1;
    bus.wr_ready = 1'b1;
    wait_done("bp", db);
    n_cmp++; if (w_idx.size() - wb !== 4) begin n_err++; $display("FAIL bp_write_count: got %0d expected 4", w_idx.size() - wb); end
    for (int i = 0; i < 4; i++) begin
      if (w_idx.size() > wb + i) begin
        n_cmp++; if (w_idx[wb+i] !== VLEN_W'(i)) begin n_err++; $display("FAIL bp_idx%0d: got %0d expected %0d", i, w_idx[wb+i], i); end
        n_cmp++; if (w_data[wb+i] !== 32'h20 + WIDTH'(i)) begin n_err++; $display("FAIL bp_data%0d: got %0h expected %0h", i, w_data[wb+i], 32'h20 + i); end
      end
    end
  endtask

  task automatic test_predicate();
    int s, wb, db, exp_n;
    int exp_idx [4];
`ifdef ALU_WB_PRED_MASK_EN
    exp_n = 2; exp_idx[0] = 0; exp_idx[1] = 2; exp_idx[2] = 0; exp_idx[3] = 0;
`else
    exp_n = 4; exp_idx[0] = 0; exp_idx[1] = 1; exp_idx[2] = 2; exp_idx[3] = 3;
`endif
    bus.wr_ready = 1'b1;
    wb = w_idx.size();
    db = done_cnt;
    load_src(4, 32'h30, 16'b0101);
    do_start(4, s);
    wait_done("pred", db);
    n_cmp++; if (w_idx.size() - wb !== exp_n) begin n_err++; $display("FAIL pred_write_count: got %0d expected %0d", w_idx.size() - wb, exp_n); end
    for (int i = 0; i < exp_n; i++) begin
      if (w_idx.size() > wb + i) begin
        n_cmp++; if (w_idx[wb+i] !== VLEN_W'(exp_idx[i])) begin n_err++; $display("FAIL pred_idx%0d: got %0d expected %0d", i, w_idx[wb+i], exp_idx[i]); end
        n_cmp++; if (w_data[wb+i] !== 32'h30 + WIDTH'(exp_idx[i])) begin n_err++; $display("FAIL pred_data%0d: got %0h expected %0h", i, w_data[wb+i], 32'h30 + exp_idx[i]); end
      end
    end
    repeat (3) @(negedge clk);
    n_cmp++; if (done_cnt - db !== 1) begin n_err++; $display("FAIL pred_done_count: got %0d expected 1", done_cnt - db); end
  endtask

  task automatic test_zero_len();
    int s, db, we, ir;
    bus.wr_ready = 1'b1;
    load_src(0, 32'h0, 16'h0);
    db = done_cnt;
    we = wr_en_cnt;
    ir = in_ready_cnt;
    do_start(0, s);
    wait_done("zero", db);
    n_cmp++; if (done_cyc - s !== 1) begin n_err++; $display("FAIL zero_done_latency: got %0d expected 1", done_cyc - s); end
    n_cmp++; if (wr_en_cnt - we !== 0) begin n_err++; $display("FAIL zero_wr_en_cycles: got %0d expected 0", wr_en_cnt - we); end
    n_cmp++; if (in_ready_cnt - ir !== 0) begin n_err++; $display("FAIL zero_in_ready_cycles: got %0d expected 0", in_ready_cnt - ir); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy_after_done: got %0h expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    int s, wb, db, k;
    bus.wr_ready = 1'b1;
    load_src(8, 32'h40, 16'hFF);
    do_start(8, s);
    for (k = 0; k < 40; k++) begin
      if (src_pos >= src_lo + 3) break;
      @(posedge clk); #1;
    end
    n_cmp++; if (src_pos - src_lo !== 3) begin n_err++; $display("FAIL rstmid_accepts: got %0d expected 3", src_pos - src_lo); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_in_ready: got %0h expected 0", bus.in_ready); end
    n_cmp++; if (bus.wr_en    !== 1'b0) begin n_err++; $display("FAIL rstmid_wr_en: got %0h expected 0", bus.wr_en); end
    n_cmp++; if (bus.wr_idx   !== '0)   begin n_err++; $display("FAIL rstmid_wr_idx: got %0h expected 0", bus.wr_idx); end
    n_cmp++; if (bus.wr_data  !== '0)   begin n_err++; $display("FAIL rstmid_wr_data: got %0h expected 0", bus.wr_data); end
    n_cmp++; if (busy         !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %0h expected 0", busy); end
    n_cmp++; if (done         !== 1'b0) begin n_err++; $display("FAIL rstmid_done: got %0h expected 0", done); end
    load_src(2, 32'h50, 16'h3);
    @(negedge clk);
    rst_n = 1'b1;
    wb = w_idx.size();
    db = done_cnt;
    do_start(2, s);
    wait_done("rstmid", db);
    n_cmp++; if (w_idx.size() - wb !== 2) begin n_err++; $display("FAIL rstmid_write_count: got %0d expected 2", w_idx.size() - wb); end
    for (int i = 0; i < 2; i++) begin
      if (w_idx.size() > wb + i) begin
        n_cmp++; if (w_idx[wb+i] !== VLEN_W'(i)) begin n_err++; $display("FAIL rstmid_idx%0d: got %0d expected %0d", i, w_idx[wb+i], i); end
        n_cmp++; if (w_data[wb+i] !== 32'h50 + WIDTH'(i)) begin n_err++; $display("FAIL rstmid_data%0d: got %0h expected %0h", i, w_data[wb+i], 32'h50 + i); end
      end
    end
  endtask

  task automatic test_start_busy();
    int s, s2, wb, db;
    bus.wr_ready = 1'b1;
    wb = w_idx.size();
    db = done_cnt;
    load_src(6, 32'h60, 16'h3F);
    do_start(3, s);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL busy_during_run: got %0h expected 1", busy); end
    do_start(6, s2);
    wait_done("startbusy", db);
    repeat (12) @(negedge clk);
    n_cmp++; if (w_idx.size() - wb !== 3) begin n_err++; $display("FAIL startbusy_write_count: got %0d expected 3", w_idx.size() - wb); end
    for (int i = 0; i < 3; i++) begin
      if (w_idx.size() > wb + i) begin
        n_cmp++; if (w_idx[wb+i] !== VLEN_W'(i)) begin n_err++; $display("FAIL startbusy_idx%0d: got %0d expected %0d", i, w_idx[wb+i], i); end
        n_cmp++; if (w_data[wb+i] !== 32'h60 + WIDTH'(i)) begin n_err++; $display("FAIL startbusy_data%0d: got %0h expected %0h", i, w_data[wb+i], 32'h60 + i); end
      end
    end
    n_cmp++; if (done_cnt - db !== 1) begin n_err++; $display("FAIL startbusy_done_count: got %0d expected 1", done_cnt - db); end
  endtask

  initial begin
    bus.wr_ready = 1'b1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_predicate();
    test_zero_len();
    test_reset_mid();
    test_start_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
